// File: rtl/bcp_dispatch_pkg.sv
// Shared types for the BCP clause dispatcher: FSM state encoding and core-count defaults.
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

package bcp_dispatch_pkg;

  localparam int BCP_NUM_CORES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bcp_disp_state_t;

  // Index width for a core number; a single core still needs a 1-bit pointer.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bcp_dispatch_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr_i, wrapping.
module bcp_dispatch_rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_vld_o
);

  logic found;

  // First pass covers [ptr, N-1], second pass the wrapped part [0, ptr-1].
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req_i[j] && (IW'(j) >= ptr_i)) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req_i[j] && (IW'(j) < ptr_i)) begin
        found     = 1'b1;
        gnt_o[j]  = 1'b1;
        gnt_idx_o = IW'(j);
      end
    end
  end

  assign gnt_vld_o = found;

endmodule

// File: rtl/bcp_dispatch.sv
// Spreads a variable's clause range over NUM_CORES BCP cores, one clause per cycle,
// and reports a combined busy/done/conflict result.
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 8
`endif

module bcp_dispatch
  import bcp_dispatch_pkg::*;
#(
  parameter int NUM_CORES = BCP_NUM_CORES_DEF,
  parameter int CLAUSE_W  = `MAX_CLAUSES_BITS
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CLAUSE_W-1:0]  start_clause,
  input  logic [CLAUSE_W-1:0]  end_clause,
  input  logic                 abort,
  input  logic [NUM_CORES-1:0] core_ready,
  output logic [NUM_CORES-1:0] core_issue,
  output logic [CLAUSE_W-1:0]  core_clause_idx,
  input  logic [NUM_CORES-1:0] core_done,
  input  logic [NUM_CORES-1:0] core_conflict,
  output logic                 busy,
  output logic                 done,
  output logic                 conflict,
  output logic [CLAUSE_W-1:0]  conflict_clause_idx
);

  localparam int IW = idx_w(NUM_CORES);

  bcp_disp_state_t       state_q, state_d;
  logic [NUM_CORES-1:0]  inflight_q, inflight_d;
  logic [IW-1:0]         rr_q, rr_d;
  logic [CLAUSE_W:0]     next_idx_q, next_idx_d;
  logic [CLAUSE_W-1:0]   last_q, last_d;
  logic                  aborted_q, aborted_d;
  logic                  conflict_q, conflict_d;
  logic [CLAUSE_W-1:0]   cidx_q, cidx_d;
  logic [CLAUSE_W-1:0]   clause_q [NUM_CORES];

  logic [NUM_CORES-1:0]  done_vld, conf_vld, live, req, grant;
  logic [IW-1:0]         gnt_idx;
  logic                  gnt_vld;
  logic                  new_conf;
  logic [CLAUSE_W-1:0]   conf_clause;

  // Completions only count for cores we actually issued to; a finishing core may be re-issued at once.
  assign done_vld = core_done & inflight_q;
  assign conf_vld = done_vld & core_conflict;
  assign live     = inflight_q & ~done_vld;
  assign req      = core_ready & ~live;
  assign new_conf = ~conflict_q & (|conf_vld);

  always_comb begin
    conf_clause = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (conf_vld[i]) conf_clause = clause_q[i];
    end
  end

  bcp_dispatch_rr_arbiter #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_arb (
    .req_i     (req),
    .ptr_i     (rr_q),
    .gnt_o     (grant),
    .gnt_idx_o (gnt_idx),
    .gnt_vld_o (gnt_vld)
  );

  always_comb begin
    state_d    = state_q;
    inflight_d = live;
    rr_d       = rr_q;
    next_idx_d = next_idx_q;
    last_d     = last_q;
    aborted_d  = aborted_q;
    conflict_d = conflict_q;
    cidx_d     = cidx_q;
    core_issue = '0;

    if (new_conf) begin
      conflict_d = 1'b1;
      cidx_d     = conf_clause;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          next_idx_d = {1'b0, start_clause};
          last_d     = end_clause;
          aborted_d  = 1'b0;
          conflict_d = 1'b0;
          cidx_d     = '0;
          state_d    = (start_clause > end_clause) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = ST_DRAIN;
        end else if (new_conf) begin
          state_d = ST_DRAIN;
        end else if (gnt_vld) begin
          core_issue = grant;
          inflight_d = live | grant;
          next_idx_d = next_idx_q + {{CLAUSE_W{1'b0}}, 1'b1};
          rr_d       = (gnt_idx == IW'(NUM_CORES - 1)) ? '0 : gnt_idx + IW'(1);
          if (next_idx_q[CLAUSE_W-1:0] == last_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (abort) aborted_d = 1'b1;
        if (live == '0) state_d = (aborted_q || abort) ? ST_IDLE : ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      inflight_q <= '0;
      rr_q       <= '0;
      aborted_q  <= 1'b0;
      conflict_q <= 1'b0;
      cidx_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      rr_q       <= rr_d;
      aborted_q  <= aborted_d;
      conflict_q <= conflict_d;
      cidx_q     <= cidx_d;
    end
  end

  always_ff @(posedge clock) begin
    next_idx_q <= next_idx_d;
    last_q     <= last_d;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (core_issue[i]) clause_q[i] <= next_idx_q[CLAUSE_W-1:0];
    end
  end

  assign busy                = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done                = (state_q == ST_DONE);
  assign conflict            = conflict_q;
  assign conflict_clause_idx = cidx_q;
  assign core_clause_idx     = (|core_issue) ? next_idx_q[CLAUSE_W-1:0] : '0;

endmodule

// File: tb/tb_bcp_dispatch.sv
// Bench for bcp_dispatch: directed ranges plus randomized ranges against a transaction-level model.
module tb_bcp_dispatch;

  localparam int N = 2;
  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] start_clause, end_clause;
  logic         abort;
  logic [N-1:0] core_ready, core_issue, core_done, core_conflict;
  logic [W-1:0] core_clause_idx, conflict_clause_idx;
  logic         busy, done, conflict;

  bcp_dispatch #(.NUM_CORES(N), .CLAUSE_W(W)) dut (
    .clock               (clock),
    .reset               (reset),
    .start               (start),
    .start_clause        (start_clause),
    .end_clause          (end_clause),
    .abort               (abort),
    .core_ready          (core_ready),
    .core_issue          (core_issue),
    .core_clause_idx     (core_clause_idx),
    .core_done           (core_done),
    .core_conflict       (core_conflict),
    .busy                (busy),
    .done                (done),
    .conflict            (conflict),
    .conflict_clause_idx (conflict_clause_idx)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  // environment: fake cores answering after a latency
  bit           rdy_rand, lat_rand, rnd_start;
  logic [N-1:0] rdy_fix;
  int           lat_fix [N];
  bit   [255:0] conf_on;
  bit           env_busy [N];
  int           env_due [N];
  logic [W-1:0] env_clause [N];
  int           cyc = 0;
  int           iss_idx[$];
  int           iss_core[$];
  int           n_done;

  // reference model state
  int     m_phase;  // 0 idle, 1 issuing, 2 draining, 3 done pulse
  bit [N-1:0] m_infl;
  int     m_rr, m_next, m_last, m_cidx;
  bit     m_conf, m_ab;
  int     m_clause [N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_phase = 0; m_infl = '0; m_rr = 0; m_conf = 0; m_cidx = 0; m_ab = 0;
  endtask

  task automatic model_step();
    logic [N-1:0] dv, cv, exp_iss;
    int pick, lo;
    bit newc;
    chk("busy", busy, (m_phase == 1 || m_phase == 2));
    chk("done", done, (m_phase == 3));
    chk("conflict", conflict, m_conf);
    chk("conflict_idx", conflict_clause_idx, m_cidx);
    dv = core_done & m_infl;
    cv = dv & core_conflict;
    newc = !m_conf && (cv != '0);
    pick = -1;
    exp_iss = '0;
    if (m_phase == 1 && !abort && !newc) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_rr + k) % N;
        if (pick < 0 && core_ready[c] && !(m_infl[c] && !dv[c])) pick = c;
      end
    end
    if (pick >= 0) exp_iss[pick] = 1'b1;
    chk("core_issue", core_issue, exp_iss);
    chk("core_clause_idx", core_clause_idx, (pick >= 0) ? m_next : 0);
    if (newc) begin
      lo = -1;
      for (int k = 0; k < N; k++) if (lo < 0 && cv[k]) lo = k;
      m_conf = 1; m_cidx = m_clause[lo];
    end
    m_infl = m_infl & ~dv;
    if (pick >= 0) begin
      m_infl[pick] = 1'b1; m_clause[pick] = m_next; m_rr = (pick + 1) % N;
    end
    case (m_phase)
      0: if (start) begin
        m_next = start_clause; m_last = end_clause; m_conf = 0; m_cidx = 0; m_ab = 0;
        m_phase = (start_clause > end_clause) ? 3 : 1;
      end
      1: if (abort) begin m_ab = 1; m_phase = 2; end
         else if (newc) m_phase = 2;
         else if (pick >= 0) begin
           if (m_next == m_last) m_phase = 2;
           m_next++;
         end
      2: begin
        if (abort) m_ab = 1;
        if (m_infl == '0) m_phase = m_ab ? 0 : 3;
      end
      default: m_phase = 0;
    endcase
    if (reset) model_reset();
  endtask

  task automatic cycle();
    for (int i = 0; i < N; i++) begin
      core_done[i]     = env_busy[i] && (env_due[i] == cyc);
      core_conflict[i] = core_done[i] && conf_on[env_clause[i]];
    end
    core_ready = rdy_rand ? N'($urandom) : rdy_fix;
    @(negedge clock);
    model_step();
    for (int i = 0; i < N; i++) begin
      if (core_done[i]) env_busy[i] = 0;
      if (core_issue[i]) begin
        env_busy[i]   = 1;
        env_due[i]    = cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat_fix[i]);
        env_clause[i] = core_clause_idx;
        iss_idx.push_back(int'(core_clause_idx));
        iss_core.push_back(i);
      end
    end
    n_done += int'(done);
    cyc++;
    @(posedge clock); #1;
  endtask

  task automatic reset_dut();
    reset = 1; cycle(); reset = 0;
  endtask

  task automatic run_range(input int s, input int e, input int abort_at);
    iss_idx.delete(); iss_core.delete(); n_done = 0;
    start_clause = W'(s); end_clause = W'(e);
    start = 1; cycle(); start = 0;
    for (int k = 0; k < 300 && m_phase != 0; k++) begin
      abort = (k == abort_at);
      start = rnd_start && ($urandom_range(0, 7) == 0);
      cycle();
      abort = 0; start = 0;
    end
    if (m_phase != 0) chk("range_timeout", 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

  initial begin
    reset = 1; start = 0; abort = 0; start_clause = '0; end_clause = '0;
    core_ready = '0; core_done = '0; core_conflict = '0;
    rdy_rand = 0; lat_rand = 0; rnd_start = 0; rdy_fix = '1; conf_on = '0;
    for (int i = 0; i < N; i++) begin lat_fix[i] = 2; env_busy[i] = 0; env_due[i] = 0; env_clause[i] = '0; end
    repeat (3) @(posedge clock);
    #1; reset = 0;
    model_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_conflict", conflict, 0);
    chk("rst_cidx", conflict_clause_idx, 0);
    chk("rst_issue", core_issue, 0);

    // range 0..5, both ready, latency 2
    reset_dut();
    run_range(0, 5, -1);
    chk("t1_count", iss_idx.size(), 6);
    for (int i = 0; i < iss_idx.size(); i++) begin
      chk("t1_idx", iss_idx[i], i);
      chk("t1_core", iss_core[i], i % 2);
    end
    chk("t1_done", n_done, 1);
    chk("t1_conflict", conflict, 0);

    // conflict on clause 6 from core 1
    reset_dut();
    conf_on = '0; conf_on[6] = 1;
    run_range(3, 10, -1);
    chk("t2_count", iss_idx.size(), 5);
    if (iss_core.size() > 3) chk("t2_core_of_6", iss_core[3], 1);
    chk("t2_done", n_done, 1);
    chk("t2_conflict", conflict, 1);
    chk("t2_cidx", conflict_clause_idx, 6);

    // simultaneous conflicts on 8 (core 0) and 9 (core 1)
    reset_dut();
    conf_on = '0; conf_on[8] = 1; conf_on[9] = 1;
    lat_fix[0] = 3; lat_fix[1] = 2;
    run_range(8, 12, -1);
    chk("t3_count", iss_idx.size(), 2);
    chk("t3_done", n_done, 1);
    chk("t3_conflict", conflict, 1);
    chk("t3_cidx", conflict_clause_idx, 8);

    // empty range
    lat_fix[0] = 2; lat_fix[1] = 2; conf_on = '0;
    run_range(7, 4, -1);
    chk("t4_count", iss_idx.size(), 0);
    chk("t4_done", n_done, 1);
    chk("t4_conflict", conflict, 0);

    // top of the index space
    run_range(253, 255, -1);
    chk("t5_count", iss_idx.size(), 3);
    for (int i = 0; i < iss_idx.size(); i++) chk("t5_idx", iss_idx[i], 253 + i);
    chk("t5_done", n_done, 1);

    // abort with one core in flight
    reset_dut();
    rdy_fix = 2'b01; lat_fix[0] = 5;
    run_range(0, 20, 2);
    chk("t6_count", iss_idx.size(), 1);
    chk("t6_no_done", n_done, 0);
    chk("t6_busy", busy, 0);

    // reset in the middle of a range
    rdy_fix = '1; lat_fix[0] = 2;
    iss_idx.delete(); iss_core.delete(); n_done = 0;
    start_clause = 8'd0; end_clause = 8'd50;
    start = 1; cycle(); start = 0;
    repeat (4) cycle();
    reset_dut();
    chk("t7_busy", busy, 0);
    chk("t7_done", done, 0);
    chk("t7_conflict", conflict, 0);
    chk("t7_cidx", conflict_clause_idx, 0);
    chk("t7_issue", core_issue, 0);
    chk("t7_clause_idx", core_clause_idx, 0);
    repeat (8) cycle();
    chk("t7_no_done", n_done, 0);

    // randomized ranges
    rdy_rand = 1; lat_rand = 1; rnd_start = 1;
    for (int t = 0; t < 25; t++) begin
      int s, e, ab;
      bit any_conf;
      s = $urandom_range(0, 40);
      e = s + $urandom_range(0, 16) - 2;
      if (e < 0) e = 0;
      for (int c = 0; c < 256; c++) conf_on[c] = ($urandom_range(0, 14) == 0);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1;
      run_range(s, e, ab);
      for (int i = 0; i < iss_idx.size(); i++) chk("r_seq", iss_idx[i], s + i);
      any_conf = 0;
      for (int c = s; c <= e; c++) if (conf_on[c]) any_conf = 1;
      if (ab < 0) begin
        chk("r_done", n_done, 1);
        if (s > e) chk("r_empty", iss_idx.size(), 0);
        else if (!any_conf) begin
          chk("r_count", iss_idx.size(), e - s + 1);
          chk("r_noconf", conflict, 0);
        end else begin
          chk("r_conf", conflict, 1);
          chk("r_cidx_marked", conf_on[conflict_clause_idx], 1);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
